// File: rtl/calc_host.sv
// calc_host: UART initiator that sends op/a/b as three frames, then waits for a one-byte result.
// Optional macro CALC_HOST_PARITY_EN turns frames into 8E1 and adds the resp_perr port.
module calc_host #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 2000000,
  parameter int CNT_W        = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic       tx,
  input  logic       rx,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_timeout,
  output logic       resp_ferr,
`ifdef CALC_HOST_PARITY_EN
  output logic       resp_perr,
`endif
  output logic       busy
);

  localparam int CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef CALC_HOST_PARITY_EN
  localparam logic [3:0] PAR_BIT  = 4'd9;
  localparam logic [3:0] STOP_BIT = 4'd10;
`else
  localparam logic [3:0] STOP_BIT = 4'd9;
`endif
  localparam logic [CLK_W-1:0] BIT_LAST = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CLK_W-1:0] BIT_MID  = CLK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TX_BYTE = 3'd1,
    WAIT_RX = 3'd2,
    RX_BYTE = 3'd3,
    RESP    = 3'd4
  } state_t;

`ifdef CALC_HOST_PARITY_EN
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  // Line level of bit slot b (0 = start, 1..8 = data LSB first, then parity/stop).
  function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] b);
    logic v;
    if (b == 4'd0) v = 1'b0;
    else if (b <= 4'd8) v = d[3'(b - 4'd1)];
`ifdef CALC_HOST_PARITY_EN
    else if (b == PAR_BIT) v = even_parity(d);
`endif
    else v = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [1:0] idx, input logic [7:0] op,
                                          input logic [7:0] a, input logic [7:0] b);
    logic [7:0] v;
    case (idx)
      2'd0:    v = op;
      2'd1:    v = a;
      default: v = b;
    endcase
    return v;
  endfunction

  state_t           state_r, state_n;
  logic [CLK_W-1:0] clk_cnt_r, clk_cnt_n;
  logic [3:0]       bit_r, bit_n;
  logic [1:0]       idx_r, idx_n;
  logic [7:0]       op_r, op_n, a_r, a_n, b_r, b_n;
  logic [CNT_W-1:0] to_cnt_r, to_cnt_n;
  logic [7:0]       rx_shift_r, rx_shift_n;
  logic [7:0]       resp_data_r, resp_data_n;
  logic             resp_timeout_r, resp_timeout_n;
  logic             resp_ferr_r, resp_ferr_n;
  logic             resp_valid_r, req_ready_r, busy_r, tx_r, tx_n;
  logic             rx_meta_r, rx_sync_r, rx_prev_r;
  logic             bit_end_s, mid_s, rx_fall_s;
`ifdef CALC_HOST_PARITY_EN
  logic             perr_r, perr_n, resp_perr_r, resp_perr_n;
`endif

  // Next-state, datapath and response field computation.
  always_comb begin
    state_n        = state_r;
    clk_cnt_n      = clk_cnt_r;
    bit_n          = bit_r;
    idx_n          = idx_r;
    op_n           = op_r;
    a_n            = a_r;
    b_n            = b_r;
    to_cnt_n       = to_cnt_r;
    rx_shift_n     = rx_shift_r;
    resp_data_n    = resp_data_r;
    resp_timeout_n = resp_timeout_r;
    resp_ferr_n    = resp_ferr_r;
`ifdef CALC_HOST_PARITY_EN
    perr_n         = perr_r;
    resp_perr_n    = resp_perr_r;
`endif
    bit_end_s = (clk_cnt_r == BIT_LAST);
    mid_s     = (clk_cnt_r == BIT_MID);
    rx_fall_s = rx_prev_r & ~rx_sync_r;

    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_n   = TX_BYTE;
          op_n      = req_op;
          a_n       = req_a;
          b_n       = req_b;
          clk_cnt_n = '0;
          bit_n     = 4'd0;
          idx_n     = 2'd0;
        end else begin
          state_n = IDLE;
        end
      end
      TX_BYTE: begin
        if (bit_end_s) begin
          clk_cnt_n = '0;
          if (bit_r != STOP_BIT) begin
            bit_n = bit_r + 4'd1;
          end else if (idx_r == 2'd2) begin
            state_n  = WAIT_RX;
            to_cnt_n = '0;
          end else begin
            idx_n = idx_r + 2'd1;
            bit_n = 4'd0;
          end
        end else begin
          clk_cnt_n = clk_cnt_r + CLK_W'(1);
        end
      end
      WAIT_RX: begin
        // A start edge takes priority over an expiring timeout in the same cycle.
        if (rx_fall_s) begin
          state_n   = RX_BYTE;
          clk_cnt_n = '0;
          bit_n     = 4'd0;
`ifdef CALC_HOST_PARITY_EN
          perr_n    = 1'b0;
`endif
        end else if (to_cnt_r == TO_LAST) begin
          state_n        = RESP;
          resp_data_n    = 8'h00;
          resp_timeout_n = 1'b1;
          resp_ferr_n    = 1'b0;
`ifdef CALC_HOST_PARITY_EN
          resp_perr_n    = 1'b0;
`endif
        end else begin
          to_cnt_n = to_cnt_r + CNT_W'(1);
        end
      end
      RX_BYTE: begin
        if (bit_end_s) begin
          clk_cnt_n = '0;
          bit_n     = bit_r + 4'd1;
        end else begin
          clk_cnt_n = clk_cnt_r + CLK_W'(1);
        end
        if (mid_s) begin
          if (bit_r == 4'd0) begin
            state_n = rx_sync_r ? WAIT_RX : RX_BYTE;
          end else if (bit_r == STOP_BIT) begin
            state_n        = RESP;
            resp_data_n    = rx_shift_r;
            resp_timeout_n = 1'b0;
            resp_ferr_n    = ~rx_sync_r;
`ifdef CALC_HOST_PARITY_EN
            resp_perr_n    = perr_r;
          end else if (bit_r == PAR_BIT) begin
            perr_n = rx_sync_r ^ even_parity(rx_shift_r);
`endif
          end else begin
            rx_shift_n = {rx_sync_r, rx_shift_r[7:1]};
          end
        end else begin
          rx_shift_n = rx_shift_r;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    tx_n = (state_n == TX_BYTE) ? frame_bit(byte_sel(idx_n, op_n, a_n, b_n), bit_n) : 1'b1;
  end

  // State, datapath, synchroniser and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      clk_cnt_r      <= '0;
      bit_r          <= 4'd0;
      idx_r          <= 2'd0;
      op_r           <= 8'h00;
      a_r            <= 8'h00;
      b_r            <= 8'h00;
      to_cnt_r       <= '0;
      rx_shift_r     <= 8'h00;
      resp_data_r    <= 8'h00;
      resp_timeout_r <= 1'b0;
      resp_ferr_r    <= 1'b0;
      resp_valid_r   <= 1'b0;
      req_ready_r    <= 1'b1;
      busy_r         <= 1'b0;
      tx_r           <= 1'b1;
      rx_meta_r      <= 1'b1;
      rx_sync_r      <= 1'b1;
      rx_prev_r      <= 1'b1;
`ifdef CALC_HOST_PARITY_EN
      perr_r         <= 1'b0;
      resp_perr_r    <= 1'b0;
`endif
    end else begin
      state_r        <= state_n;
      clk_cnt_r      <= clk_cnt_n;
      bit_r          <= bit_n;
      idx_r          <= idx_n;
      op_r           <= op_n;
      a_r            <= a_n;
      b_r            <= b_n;
      to_cnt_r       <= to_cnt_n;
      rx_shift_r     <= rx_shift_n;
      resp_data_r    <= resp_data_n;
      resp_timeout_r <= resp_timeout_n;
      resp_ferr_r    <= resp_ferr_n;
      resp_valid_r   <= (state_n == RESP);
      req_ready_r    <= (state_n == IDLE);
      busy_r         <= (state_n != IDLE);
      tx_r           <= tx_n;
      rx_meta_r      <= rx;
      rx_sync_r      <= rx_meta_r;
      rx_prev_r      <= rx_sync_r;
`ifdef CALC_HOST_PARITY_EN
      perr_r         <= perr_n;
      resp_perr_r    <= resp_perr_n;
`endif
    end
  end

  assign req_ready    = req_ready_r;
  assign tx           = tx_r;
  assign resp_valid   = resp_valid_r;
  assign resp_data    = resp_data_r;
  assign resp_timeout = resp_timeout_r;
  assign resp_ferr    = resp_ferr_r;
  assign busy         = busy_r;
`ifdef CALC_HOST_PARITY_EN
  assign resp_perr    = resp_perr_r;
`endif

endmodule

// File: tb/tb_calc_host.sv
// Self-checking bench for calc_host: random requests and replies against a frame-level model.
module tb_calc_host;
  localparam int CPB   = 8;
  localparam int TO    = 100;
  localparam int LIMIT = 400;
`ifdef CALC_HOST_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_op = 8'h00, req_a = 8'h00, req_b = 8'h00;
  logic       rx = 1'b1;
  logic       req_ready, tx, resp_valid, resp_timeout, resp_ferr, busy;
  logic [7:0] resp_data;
`ifdef CALC_HOST_PARITY_EN
  logic       resp_perr;
  logic       r_pe;
`endif

  int checks = 0;
  int fails  = 0;

  // Observations filled by the helper tasks, checked by the test tasks.
  int         r_lat, c_bad, c_rdy, c_idle;
  logic [7:0] r_data;
  logic       r_to, r_fe, r_tx0, r_rv_next, r_rdy_next;

  calc_host #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .tx(tx), .rx(rx),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_timeout(resp_timeout),
    .resp_ferr(resp_ferr),
`ifdef CALC_HOST_PARITY_EN
    .resp_perr(resp_perr),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Expected tx level i cycles after the first start bit of a request.
  function automatic logic exp_tx_bit(input logic [7:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input int i);
    int fb, bi;
    logic [7:0] d;
    fb = i / (FRAME * CPB);
    bi = (i % (FRAME * CPB)) / CPB;
    d  = (fb == 0) ? op : ((fb == 1) ? a : b);
    if (bi == 0) return 1'b0;
    if (bi <= 8) return d[bi-1];
`ifdef CALC_HOST_PARITY_EN
    if (bi == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Cycles from end of last tx stop bit to resp_valid, for a reply starting 'gap' cycles later.
  function automatic int exp_lat(input int gap);
    return gap + (FRAME - 1) * CPB + CPB / 2 + 3;
  endfunction

  task automatic accept_req(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                            input bit hold, output bit ok);
    ok = 1'b0;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic capture_tx(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                            input bit vary);
    c_bad = 0; c_rdy = 0; c_idle = 0;
    for (int i = 0; i < 3 * FRAME * CPB; i++) begin
      @(negedge clk);
      if (tx !== exp_tx_bit(op, a, b, i)) c_bad++;
      if (req_ready !== 1'b0) c_rdy++;
      if (busy !== 1'b1) c_idle++;
      if (vary) begin
        req_op = 8'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
      end
    end
    @(posedge clk);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop, input int gap, input int glitch_at);
    if (glitch_at >= 0) begin
      repeat (glitch_at) @(posedge clk);
      #1 rx = 1'b0;
      repeat (2) @(posedge clk);
      #1 rx = 1'b1;
      repeat (gap - glitch_at - 2) @(posedge clk);
    end else begin
      repeat (gap) @(posedge clk);
    end
    #1 rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      #1 rx = d[k];
      repeat (CPB) @(posedge clk);
    end
`ifdef CALC_HOST_PARITY_EN
    #1 rx = ^d;
    repeat (CPB) @(posedge clk);
`endif
    #1 rx = stop;
    repeat (CPB) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  task automatic watch_resp();
    r_lat = -1; r_data = 8'h00; r_to = 1'b0; r_fe = 1'b0; r_tx0 = 1'b0;
    r_rv_next = 1'b1; r_rdy_next = 1'b0;
    for (int n = 0; n < LIMIT; n++) begin
      @(negedge clk);
      if (n == 0) r_tx0 = tx;
      if (resp_valid) begin
        r_lat = n; r_data = resp_data; r_to = resp_timeout; r_fe = resp_ferr;
`ifdef CALC_HOST_PARITY_EN
        r_pe = resp_perr;
`endif
        @(negedge clk);
        r_rv_next = resp_valid; r_rdy_next = req_ready;
        break;
      end
    end
  endtask

  task automatic reply_and_wait(input bit send, input logic [7:0] d, input logic stop,
                                input int gap, input int glitch_at);
    if (send) begin
      fork
        send_rx(d, stop, gap, glitch_at);
        watch_resp();
      join
    end else begin
      watch_resp();
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if ({resp_valid, resp_timeout, resp_ferr, busy} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b want 0000", {resp_valid, resp_timeout, resp_ferr, busy}); end
    checks++; if (resp_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", resp_data); end
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({tx, req_ready, busy} !== 3'b110) begin
      fails++; $display("FAIL idle_after_reset: got %b want 110", {tx, req_ready, busy}); end
  endtask

  task automatic test_basic();
    bit ok;
    logic [7:0] op, a, b, d;
    int gap;
    accept_req(8'h2B, 8'h05, 8'h03, 1'b0, ok);
    checks++; if (!ok) begin fails++; $display("FAIL basic_accept: got 0 want 1"); end
    capture_tx(8'h2B, 8'h05, 8'h03, 1'b0);
    checks++; if (c_bad != 0) begin fails++; $display("FAIL basic_tx_bits: got %0d bad cycles want 0", c_bad); end
    checks++; if (c_rdy != 0 || c_idle != 0) begin
      fails++; $display("FAIL basic_ready_busy: got ready %0d idle %0d want 0 0", c_rdy, c_idle); end
    reply_and_wait(1'b1, 8'h08, 1'b1, 20, -1);
    checks++; if (r_tx0 !== 1'b1) begin fails++; $display("FAIL basic_tx_end: got %b want 1", r_tx0); end
    checks++; if (r_lat != exp_lat(20)) begin fails++; $display("FAIL basic_latency: got %0d want %0d", r_lat, exp_lat(20)); end
    checks++; if (r_data !== 8'h08 || r_to !== 1'b0 || r_fe !== 1'b0) begin
      fails++; $display("FAIL basic_resp: got %h/%b/%b want 08/0/0", r_data, r_to, r_fe); end
`ifdef CALC_HOST_PARITY_EN
    checks++; if (r_pe !== 1'b0) begin fails++; $display("FAIL basic_perr: got %b want 0", r_pe); end
`endif
    checks++; if (r_rv_next !== 1'b0 || r_rdy_next !== 1'b1) begin
      fails++; $display("FAIL basic_pulse_ready: got valid %b ready %b want 0 1", r_rv_next, r_rdy_next); end
    repeat (5) @(negedge clk);
    checks++; if (resp_data !== 8'h08) begin fails++; $display("FAIL basic_hold: got %h want 08", resp_data); end
    for (int it = 0; it < 3; it++) begin
      op = 8'($urandom); a = 8'($urandom); b = 8'($urandom); d = 8'($urandom);
      gap = $urandom_range(0, 40);
      accept_req(op, a, b, 1'b0, ok);
      capture_tx(op, a, b, 1'b0);
      checks++; if (!ok || c_bad != 0) begin fails++; $display("FAIL rand_tx: got ok %0d bad %0d want 1 0", ok, c_bad); end
      reply_and_wait(1'b1, d, 1'b1, gap, -1);
      checks++; if (r_data !== d || r_to !== 1'b0 || r_fe !== 1'b0 || r_lat != exp_lat(gap)) begin
        fails++; $display("FAIL rand_resp: got %h/%b/%b lat %0d want %h/0/0 lat %0d", r_data, r_to, r_fe, r_lat, d, exp_lat(gap)); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [7:0] d;
    accept_req(8'($urandom), 8'h11, 8'h22, 1'b0, ok);
    capture_tx(req_op, 8'h11, 8'h22, 1'b0);
    reply_and_wait(1'b0, 8'h00, 1'b1, 0, -1);
    checks++; if (r_lat != TO) begin fails++; $display("FAIL timeout_latency: got %0d want %0d", r_lat, TO); end
    checks++; if (r_data !== 8'h00 || r_to !== 1'b1 || r_fe !== 1'b0) begin
      fails++; $display("FAIL timeout_resp: got %h/%b/%b want 00/1/0", r_data, r_to, r_fe); end
    // Start edge seen in the very cycle the timeout would expire.
    d = 8'($urandom);
    accept_req(8'h33, 8'h44, 8'h55, 1'b0, ok);
    capture_tx(8'h33, 8'h44, 8'h55, 1'b0);
    reply_and_wait(1'b1, d, 1'b1, TO - 3, -1);
    checks++; if (r_data !== d || r_to !== 1'b0 || r_lat != exp_lat(TO - 3)) begin
      fails++; $display("FAIL timeout_edge_wins: got %h/%b lat %0d want %h/0 lat %0d", r_data, r_to, r_lat, d, exp_lat(TO - 3)); end
  endtask

  task automatic test_framing();
    bit ok;
    accept_req(8'h01, 8'h02, 8'h03, 1'b0, ok);
    capture_tx(8'h01, 8'h02, 8'h03, 1'b0);
    reply_and_wait(1'b1, 8'hA5, 1'b0, 10, -1);
    checks++; if (r_data !== 8'hA5 || r_fe !== 1'b1 || r_to !== 1'b0 || r_lat != exp_lat(10)) begin
      fails++; $display("FAIL framing: got %h/%b/%b lat %0d want a5/1/0 lat %0d", r_data, r_fe, r_to, r_lat, exp_lat(10)); end
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic test_glitch();
    bit ok;
    int extra;
    accept_req(8'h10, 8'h20, 8'h30, 1'b0, ok);
    capture_tx(8'h10, 8'h20, 8'h30, 1'b0);
    reply_and_wait(1'b1, 8'h3C, 1'b1, 30, 5);
    checks++; if (r_data !== 8'h3C || r_fe !== 1'b0 || r_to !== 1'b0 || r_lat != exp_lat(30)) begin
      fails++; $display("FAIL glitch_resp: got %h/%b/%b lat %0d want 3c/0/0 lat %0d", r_data, r_fe, r_to, r_lat, exp_lat(30)); end
    extra = 0;
    for (int n = 0; n < 60; n++) begin @(negedge clk); if (resp_valid) extra++; end
    checks++; if (extra != 0) begin fails++; $display("FAIL glitch_single: got %0d extra pulses want 0", extra); end
  endtask

  task automatic test_reset_mid_tx();
    bit ok;
    logic [7:0] op, a, b, d;
    accept_req(8'hC3, 8'h5A, 8'h96, 1'b0, ok);
    repeat (FRAME * CPB + 3 * CPB) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if ({tx, req_ready, busy, resp_valid} !== 4'b1100) begin
      fails++; $display("FAIL midtx_reset: got %b want 1100", {tx, req_ready, busy, resp_valid}); end
    checks++; if (resp_data !== 8'h00) begin fails++; $display("FAIL midtx_data: got %h want 00", resp_data); end
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    op = 8'($urandom); a = 8'($urandom); b = 8'($urandom); d = 8'($urandom);
    accept_req(op, a, b, 1'b0, ok);
    capture_tx(op, a, b, 1'b0);
    checks++; if (!ok || c_bad != 0) begin fails++; $display("FAIL midtx_resend: got ok %0d bad %0d want 1 0", ok, c_bad); end
    reply_and_wait(1'b1, d, 1'b1, 7, -1);
    checks++; if (r_data !== d || r_lat != exp_lat(7)) begin
      fails++; $display("FAIL midtx_resp: got %h lat %0d want %h lat %0d", r_data, r_lat, d, exp_lat(7)); end
  endtask

  task automatic test_handshake();
    bit ok;
    logic [7:0] op0, a0, b0, op1, a1, b1, d0, d1;
    op0 = 8'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
    op1 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    d0 = 8'($urandom); d1 = 8'($urandom);
    accept_req(op0, a0, b0, 1'b1, ok);
    capture_tx(op0, a0, b0, 1'b1);
    checks++; if (!ok || c_bad != 0 || c_rdy != 0) begin
      fails++; $display("FAIL hs_first: got ok %0d bad %0d ready %0d want 1 0 0", ok, c_bad, c_rdy); end
    req_op = op1; req_a = a1; req_b = b1;
    reply_and_wait(1'b1, d0, 1'b1, 12, -1);
    checks++; if (r_data !== d0 || r_rv_next !== 1'b0 || r_rdy_next !== 1'b1) begin
      fails++; $display("FAIL hs_resp1: got %h valid %b ready %b want %h 0 1", r_data, r_rv_next, r_rdy_next, d0); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    capture_tx(op1, a1, b1, 1'b0);
    checks++; if (c_bad != 0) begin fails++; $display("FAIL hs_second_tx: got %0d bad cycles want 0", c_bad); end
    reply_and_wait(1'b1, d1, 1'b1, 3, -1);
    checks++; if (r_data !== d1 || r_lat != exp_lat(3)) begin
      fails++; $display("FAIL hs_resp2: got %h lat %0d want %h lat %0d", r_data, r_lat, d1, exp_lat(3)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_framing();
    test_glitch();
    test_reset_mid_tx();
    test_handshake();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
